// File: rtl/pcie_tx_cpl_tlp_gen_pkg.sv
// pcie_tx_cpl_tlp_gen_pkg: completion header fields, codes and TX generator state
package pcie_tx_cpl_tlp_gen_pkg;
  localparam int FMT_HASDATA_BIT = 30;
  localparam int LEN_LSB = 0;
  localparam int LEN_W = 10;
  localparam logic [2:0] FMT_CPL = 3'b000;
  localparam logic [2:0] FMT_CPLD = 3'b010;
  localparam logic [4:0] TYPE_CPL = 5'b01010;
  typedef enum logic [1:0] {IDLE, PAY, DRAIN} tx_gen_state_t;
  // Payload beats of a TLP; a zero length field encodes 1024 DW
  function automatic logic [7:0] tlp_pay_beats(input logic [LEN_W-1:0] len_dw, input logic has_data,
                                               input int dw_per_beat);
    int l;
    l = (len_dw == '0) ? 1024 : int'(len_dw);
    return has_data ? 8'((l + dw_per_beat - 1) / dw_per_beat) : 8'd0;
  endfunction
endpackage

// File: rtl/pcie_tx_cpl_tlp_gen_out_reg.sv
// pcie_tx_out_reg: single-entry valid/ready output register
import pcie_tx_cpl_tlp_gen_pkg::*;
module pcie_tx_out_reg #(
  parameter int W = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_last,
  input  logic         i_ready,
  output logic         o_free,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last
);
  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_last;
  assign o_free = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data = r_data;
  assign o_last = r_last;
  // Load a new beat when free, otherwise hold; drop valid once accepted
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data <= i_data;
      r_last <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
endmodule

// File: rtl/pcie_tx_cpl_tlp_gen.sv
// pcie_tx_cpl_tlp_gen: pops completion header/payload FIFOs and emits TLP beats
import pcie_tx_cpl_tlp_gen_pkg::*;
module pcie_tx_cpl_tlp_gen #(
  parameter int DATA_WIDTH = 256,
  parameter int DW_PER_BEAT = DATA_WIDTH / 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_hdr_empty,
  input  logic [127:0]          i_hdr_rdata,
  output logic                  o_hdr_rden,
  input  logic                  i_pay_empty,
  input  logic [DATA_WIDTH-1:0] i_pay_rdata,
  input  logic                  i_pay_rlast,
  output logic                  o_pay_rden,
  output logic                  o_tlp_out_valid,
  input  logic                  i_tlp_out_ready,
  output logic [DATA_WIDTH-1:0] o_tlp_out_data,
  output logic                  o_tlp_out_last,
  output logic                  o_err_len_pulse,
  output logic [CNT_WIDTH-1:0]  o_tlp_cnt
);
  tx_gen_state_t         r_state;
  logic [7:0]            r_rem;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_free;
  logic                  w_hdr_go;
  logic                  w_pay_go;
  logic                  w_drain_go;
  logic [7:0]            w_beats;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_last;
  assign w_beats = tlp_pay_beats(i_hdr_rdata[LEN_LSB +: LEN_W], i_hdr_rdata[FMT_HASDATA_BIT], DW_PER_BEAT);
  // Pops are gated by reset so nothing leaves the FIFOs while rst_n is low
  assign w_hdr_go = rst_n && r_state == IDLE && !i_hdr_empty && w_free;
  assign w_pay_go = rst_n && r_state == PAY && !i_pay_empty && w_free;
  assign w_drain_go = rst_n && r_state == DRAIN && !i_pay_empty;
  assign w_load = w_hdr_go || w_pay_go;
  assign w_data = w_hdr_go ? {i_hdr_rdata, {(DATA_WIDTH-128){1'b0}}} : i_pay_rdata;
  assign w_last = w_hdr_go ? (w_beats == 8'd0) : (r_rem == 8'd1 || i_pay_rlast);
  assign o_hdr_rden = w_hdr_go;
  assign o_pay_rden = w_pay_go || w_drain_go;
  assign o_err_len_pulse = r_err;
  assign o_tlp_cnt = r_cnt;
  pcie_tx_out_reg #(.W(DATA_WIDTH)) u_out (
    .clk(clk), .rst_n(rst_n), .i_load(w_load), .i_data(w_data), .i_last(w_last),
    .i_ready(i_tlp_out_ready), .o_free(w_free), .o_valid(o_tlp_out_valid),
    .o_data(o_tlp_out_data), .o_last(o_tlp_out_last)
  );
  // Header/payload sequencing, length-mismatch pulse and accepted-TLP counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_rem <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_err <= 1'b0;
      if (o_tlp_out_valid && i_tlp_out_ready && o_tlp_out_last) r_cnt <= r_cnt + 1'b1;
      case (r_state)
        IDLE:
          if (w_hdr_go) begin
            r_rem <= w_beats;
            r_state <= (w_beats != 8'd0) ? PAY : IDLE;
          end
        PAY:
          if (w_pay_go) begin
            r_rem <= r_rem - 8'd1;
            if (i_pay_rlast) begin
              r_err <= r_rem != 8'd1;
              r_state <= IDLE;
            end else if (r_rem == 8'd1) begin
              r_err <= 1'b1;
              r_state <= DRAIN;
            end
          end
        DRAIN:
          if (w_drain_go && i_pay_rlast) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pcie_tx_cpl_tlp_gen.sv
// tb_pcie_tx_cpl_tlp_gen: directed checks of the completion TLP generator
import pcie_tx_cpl_tlp_gen_pkg::*;
module tb_pcie_tx_cpl_tlp_gen;
  localparam int DW = 256;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_hdr_empty;
  logic [127:0]  i_hdr_rdata;
  logic          o_hdr_rden;
  logic          i_pay_empty;
  logic [DW-1:0] i_pay_rdata;
  logic          i_pay_rlast;
  logic          o_pay_rden;
  logic          o_tlp_out_valid;
  logic          i_tlp_out_ready = 1'b1;
  logic [DW-1:0] o_tlp_out_data;
  logic          o_tlp_out_last;
  logic          o_err_len_pulse;
  logic [31:0]   o_tlp_cnt;
  logic [127:0]  hmem [0:63];
  logic [DW-1:0] pmem [0:63];
  logic          plst [0:63];
  int            hwp = 0, hrp = 0, pwp = 0, prp = 0;
  logic [DW-1:0] bd [0:63];
  logic          bl [0:63];
  int            bc [0:63];
  int            nb = 0, cyc = 0, n_err = 0, n_prd = 0, hold_bad = 0;
  int            n_chk = 0, n_pass = 0;
  logic          stall = 1'b0, sl;
  logic [DW-1:0] sd;
  int            base, e0, p0, pc;
  logic [127:0]  ha, hb, hc, hd;
  always #5 clk = ~clk;
  pcie_tx_cpl_tlp_gen dut (
    .clk(clk), .rst_n(rst_n), .i_hdr_empty(i_hdr_empty), .i_hdr_rdata(i_hdr_rdata),
    .o_hdr_rden(o_hdr_rden), .i_pay_empty(i_pay_empty), .i_pay_rdata(i_pay_rdata),
    .i_pay_rlast(i_pay_rlast), .o_pay_rden(o_pay_rden), .o_tlp_out_valid(o_tlp_out_valid),
    .i_tlp_out_ready(i_tlp_out_ready), .o_tlp_out_data(o_tlp_out_data),
    .o_tlp_out_last(o_tlp_out_last), .o_err_len_pulse(o_err_len_pulse), .o_tlp_cnt(o_tlp_cnt)
  );
  assign i_hdr_empty = (hrp == hwp);
  assign i_hdr_rdata = hmem[hrp];
  assign i_pay_empty = (prp == pwp);
  assign i_pay_rdata = pmem[prp];
  assign i_pay_rlast = plst[prp];
  // First-word-fall-through FIFO read side
  always @(posedge clk) begin
    if (o_hdr_rden) hrp <= hrp + 1;
    if (o_pay_rden) prp <= prp + 1;
  end
  function automatic logic [127:0] mk(input logic [2:0] fmt, input logic [9:0] len, input logic [31:0] tag);
    mk = '0;
    mk[127:96] = tag;
    mk[31:29] = fmt;
    mk[28:24] = TYPE_CPL;
    mk[9:0] = len;
  endfunction
  task automatic push_h(input logic [127:0] h);
    hmem[hwp] = h;
    hwp++;
  endtask
  task automatic push_p(input logic [DW-1:0] d, input logic l);
    pmem[pwp] = d;
    plst[pwp] = l;
    pwp++;
  endtask
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic chk_beat(input string tag, input int i, input logic [DW-1:0] d, input logic l);
    chk({tag, "_data"}, bd[i], d);
    chk({tag, "_last"}, DW'(bl[i]), DW'(l));
  endtask
  task automatic step(input logic r);
    @(negedge clk);
    i_tlp_out_ready = r;
    #1;
    cyc++;
    if (stall && (!o_tlp_out_valid || o_tlp_out_data !== sd || o_tlp_out_last !== sl)) hold_bad++;
    stall = o_tlp_out_valid && !r;
    sd = o_tlp_out_data;
    sl = o_tlp_out_last;
    if (o_tlp_out_valid && r) begin
      bd[nb] = o_tlp_out_data;
      bl[nb] = o_tlp_out_last;
      bc[nb] = cyc;
      nb++;
    end
    if (o_err_len_pulse) n_err++;
    if (o_pay_rden) n_prd++;
  endtask
  function automatic logic [DW-1:0] pd(input int i);
    return {8{32'hA000_0000 + 32'(i)}};
  endfunction
  initial begin
    step(1);
    step(1);
    chk("rst_valid", DW'(o_tlp_out_valid), '0);
    chk("rst_data", o_tlp_out_data, '0);
    chk("rst_last", DW'(o_tlp_out_last), '0);
    chk("rst_err", DW'(o_err_len_pulse), '0);
    chk("rst_cnt", DW'(o_tlp_cnt), '0);
    chk("rst_rden", DW'({o_hdr_rden, o_pay_rden}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    // CplD, 8 DW, one payload beat
    ha = mk(FMT_CPLD, 10'd8, 32'h1111_0001);
    base = nb; e0 = n_err; pc = cyc;
    push_h(ha);
    push_p(DW'(32'hDEADBEEF), 1'b1);
    repeat (5) step(1);
    chk("t1_beats", DW'(nb - base), DW'(2));
    chk_beat("t1_b0", base, {ha, 128'h0}, 1'b0);
    chk_beat("t1_b1", base + 1, DW'(32'hDEADBEEF), 1'b1);
    chk("t1_lat", DW'(bc[base] - pc), DW'(1));
    chk("t1_cnt", DW'(o_tlp_cnt), DW'(1));
    chk("t1_err", DW'(n_err - e0), '0);
    // Cpl without data
    hb = mk(FMT_CPL, 10'd0, 32'h2222_0002);
    base = nb; p0 = n_prd;
    push_h(hb);
    repeat (4) step(1);
    chk("t2_beats", DW'(nb - base), DW'(1));
    chk_beat("t2_b0", base, {hb, 128'h0}, 1'b1);
    chk("t2_prd", DW'(n_prd - p0), '0);
    chk("t2_cnt", DW'(o_tlp_cnt), DW'(2));
    // two back-to-back CplD of 16 DW
    ha = mk(FMT_CPLD, 10'd16, 32'h3333_0003);
    hb = mk(FMT_CPLD, 10'd16, 32'h3333_0004);
    base = nb;
    push_h(ha); push_h(hb);
    push_p(pd(0), 1'b0); push_p(pd(1), 1'b1);
    push_p(pd(2), 1'b0); push_p(pd(3), 1'b1);
    repeat (9) step(1);
    chk("t3_beats", DW'(nb - base), DW'(6));
    chk_beat("t3_b0", base, {ha, 128'h0}, 1'b0);
    chk_beat("t3_b1", base + 1, pd(0), 1'b0);
    chk_beat("t3_b2", base + 2, pd(1), 1'b1);
    chk_beat("t3_b3", base + 3, {hb, 128'h0}, 1'b0);
    chk_beat("t3_b4", base + 4, pd(2), 1'b0);
    chk_beat("t3_b5", base + 5, pd(3), 1'b1);
    for (int i = 1; i < 6; i++) chk("t3_nobubble", DW'(bc[base + i] - bc[base + i - 1]), DW'(1));
    chk("t3_cnt", DW'(o_tlp_cnt), DW'(4));
    // ready toggling during a 3-beat TLP
    hc = mk(FMT_CPLD, 10'd16, 32'h4444_0005);
    base = nb;
    push_h(hc);
    push_p(pd(4), 1'b0); push_p(pd(5), 1'b1);
    for (int i = 0; i < 12; i++) step(i[0] ? 1'b0 : 1'b1);
    step(1);
    chk("t4_beats", DW'(nb - base), DW'(3));
    chk_beat("t4_b0", base, {hc, 128'h0}, 1'b0);
    chk_beat("t4_b1", base + 1, pd(4), 1'b0);
    chk_beat("t4_b2", base + 2, pd(5), 1'b1);
    chk("t4_hold", DW'(hold_bad), '0);
    chk("t4_cnt", DW'(o_tlp_cnt), DW'(5));
    // short payload, then a normal Cpl
    ha = mk(FMT_CPLD, 10'd16, 32'h5555_0006);
    hb = mk(FMT_CPL, 10'd0, 32'h5555_0007);
    base = nb; e0 = n_err;
    push_h(ha); push_h(hb);
    push_p(pd(6), 1'b1);
    repeat (6) step(1);
    chk("t5_beats", DW'(nb - base), DW'(3));
    chk_beat("t5_b0", base, {ha, 128'h0}, 1'b0);
    chk_beat("t5_b1", base + 1, pd(6), 1'b1);
    chk_beat("t5_b2", base + 2, {hb, 128'h0}, 1'b1);
    chk("t5_err", DW'(n_err - e0), DW'(1));
    chk("t5_cnt", DW'(o_tlp_cnt), DW'(7));
    // long payload drained, then a normal Cpl
    ha = mk(FMT_CPLD, 10'd8, 32'h6666_0008);
    hb = mk(FMT_CPL, 10'd0, 32'h6666_0009);
    base = nb; e0 = n_err; p0 = n_prd;
    push_h(ha); push_h(hb);
    push_p(pd(7), 1'b0); push_p(pd(8), 1'b0); push_p(pd(9), 1'b1);
    repeat (8) step(1);
    chk("t6_beats", DW'(nb - base), DW'(3));
    chk_beat("t6_b0", base, {ha, 128'h0}, 1'b0);
    chk_beat("t6_b1", base + 1, pd(7), 1'b1);
    chk_beat("t6_b2", base + 2, {hb, 128'h0}, 1'b1);
    chk("t6_err", DW'(n_err - e0), DW'(1));
    chk("t6_prd", DW'(n_prd - p0), DW'(3));
    chk("t6_pay_empty", DW'(i_pay_empty), DW'(1));
    chk("t6_cnt", DW'(o_tlp_cnt), DW'(9));
    // reset while a header beat is stalled and payload is pending
    push_h(mk(FMT_CPLD, 10'd16, 32'h7777_000A));
    push_p(pd(10), 1'b0);
    repeat (4) step(0);
    chk("t7_pre_valid", DW'(o_tlp_out_valid), DW'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t7_valid", DW'(o_tlp_out_valid), '0);
    chk("t7_data", o_tlp_out_data, '0);
    chk("t7_last", DW'(o_tlp_out_last), '0);
    chk("t7_cnt", DW'(o_tlp_cnt), '0);
    chk("t7_rden", DW'({o_hdr_rden, o_pay_rden}), '0);
    step(1);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = n_prd; base = nb;
    repeat (4) step(1);
    chk("t7_idle_prd", DW'(n_prd - p0), '0);
    chk("t7_idle_beats", DW'(nb - base), '0);
    chk("t7_post_cnt", DW'(o_tlp_cnt), '0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
